// File: rtl/aggregate_pkg.sv
// Shared types and sizing helpers for the frame aggregator.
package aggregate_pkg;

  // Receive-side frame states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKIP    = 2'd1,
    COLLECT = 2'd2
  } state_e;

  // Width of a lane counter that must also hold the value LANES itself.
  function automatic int lane_cnt_w(input int lanes);
    return $clog2(lanes) + 1;
  endfunction

  // Width of the header-skip counter; never narrower than one bit.
  function automatic int skip_cnt_w(input int skip_units);
    return (skip_units < 2) ? 1 : $clog2(skip_units + 1);
  endfunction

endpackage

// File: rtl/aggregate_lane_pack.sv
// Lane packing register: collects IN_W-bit units into an OUT_W-bit word,
// either shifting from the LSB end (first unit ends up on top) or writing
// lane by lane from lane 0. Also exposes a zero-filled partial-word view.
module aggregate_lane_pack
  import aggregate_pkg::*;
#(
  parameter int IN_W      = 2,
  parameter int OUT_W     = 32,
  parameter int FIRST_MSB = 1,
  parameter int LANES     = OUT_W / IN_W,
  parameter int CNT_W     = lane_cnt_w(OUT_W / IN_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [IN_W-1:0]  unit_d,
  output logic [CNT_W-1:0] lane_cnt,
  output logic             word_done,
  output logic [OUT_W-1:0] word_full,
  output logic [OUT_W-1:0] word_part
);

  logic [OUT_W-1:0] shreg_r;
  logic [CNT_W-1:0] lane_cnt_r;
  logic [OUT_W-1:0] word_nxt_s;
  logic [OUT_W-1:0] unit_ext_s;

  assign unit_ext_s = {{(OUT_W - IN_W){1'b0}}, unit_d};

  if (FIRST_MSB != 0) begin : g_msb
    // Shift-left packing; a partial word is left-aligned into the top lanes.
    always_comb begin
      word_nxt_s = {shreg_r[OUT_W-IN_W-1:0], unit_d};
      word_part  = shreg_r << (IN_W * (LANES - int'(lane_cnt_r)));
    end
  end else begin : g_lsb
    // Lane-write packing; lanes above lane_cnt are still zero.
    always_comb begin
      word_nxt_s = shreg_r | (unit_ext_s << (IN_W * int'(lane_cnt_r)));
      word_part  = shreg_r;
    end
  end

  assign word_done = load && (lane_cnt_r == CNT_W'(LANES - 1));
  assign word_full = word_nxt_s;
  assign lane_cnt  = lane_cnt_r;

  // Packing register: cleared between frames and after each completed word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r    <= {OUT_W{1'b0}};
      lane_cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      shreg_r    <= {OUT_W{1'b0}};
      lane_cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      if (word_done) begin
        shreg_r    <= {OUT_W{1'b0}};
        lane_cnt_r <= {CNT_W{1'b0}};
      end else begin
        shreg_r    <= word_nxt_s;
        lane_cnt_r <= lane_cnt_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/aggregate_frame.sv
// Frame aggregator: drops a fixed header, packs PHY units into words and
// marks the last (possibly partial) word of each frame. No backpressure.
module aggregate_frame
  import aggregate_pkg::*;
#(
  parameter int IN_W      = 2,
  parameter int OUT_W     = 32,
  parameter int SKIP_BITS = 64,
  parameter int FIRST_MSB = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         axiiv,
  input  logic [IN_W-1:0]              axiid,
  output logic                         axiov,
  output logic [OUT_W-1:0]             axiod,
  output logic                         axiol,
  output logic [$clog2(OUT_W/IN_W):0]  axiocnt,
  output logic                         axiorunt
);

  localparam int LANES      = OUT_W / IN_W;
  localparam int CNT_W      = lane_cnt_w(LANES);
  localparam int SKIP_UNITS = SKIP_BITS / IN_W;
  localparam int SKIP_W     = skip_cnt_w(SKIP_UNITS);

  if ((OUT_W % IN_W) != 0) begin : g_bad_out_w
    $error("aggregate_frame: OUT_W must be a multiple of IN_W");
  end
  if ((SKIP_BITS % IN_W) != 0) begin : g_bad_skip
    $error("aggregate_frame: SKIP_BITS must be a multiple of IN_W");
  end
  if (LANES < 2) begin : g_bad_lanes
    $error("aggregate_frame: at least two lanes per word are required");
  end

  state_e            state_r;
  state_e            state_nxt_s;
  logic [SKIP_W-1:0] skip_cnt_r;
  logic [SKIP_W-1:0] skip_nxt_s;
  logic [OUT_W-1:0]  hold_r;
  logic              hold_v_r;

  logic              load_s;
  logic              clr_s;
  logic              emit_s;
  logic              last_s;
  logic              runt_s;
  logic              from_hold_s;

  logic [CNT_W-1:0]  lane_cnt_s;
  logic              word_done_s;
  logic [OUT_W-1:0]  word_full_s;
  logic [OUT_W-1:0]  word_part_s;

  aggregate_lane_pack #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .FIRST_MSB (FIRST_MSB),
    .LANES     (LANES),
    .CNT_W     (CNT_W)
  ) u_pack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr_s),
    .load      (load_s),
    .unit_d    (axiid),
    .lane_cnt  (lane_cnt_s),
    .word_done (word_done_s),
    .word_full (word_full_s),
    .word_part (word_part_s)
  );

  // Frame FSM decode: next state, packer control and what to emit next cycle.
  always_comb begin
    state_nxt_s = state_r;
    skip_nxt_s  = skip_cnt_r;
    load_s      = 1'b0;
    clr_s       = 1'b0;
    emit_s      = 1'b0;
    last_s      = 1'b0;
    runt_s      = 1'b0;
    from_hold_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (axiiv) begin
          if (SKIP_UNITS == 0) begin
            load_s      = 1'b1;
            state_nxt_s = COLLECT;
          end else begin
            skip_nxt_s  = SKIP_W'(1);
            state_nxt_s = (SKIP_UNITS == 1) ? COLLECT : SKIP;
          end
        end else begin
          clr_s = 1'b1;
        end
      end
      SKIP: begin
        if (axiiv) begin
          skip_nxt_s = skip_cnt_r + SKIP_W'(1);
          if ((int'(skip_cnt_r) + 1) == SKIP_UNITS) begin
            state_nxt_s = COLLECT;
          end else begin
            state_nxt_s = SKIP;
          end
        end else begin
          // Frame shorter than its header: nothing was collected.
          runt_s      = 1'b1;
          clr_s       = 1'b1;
          state_nxt_s = IDLE;
        end
      end
      COLLECT: begin
        if (axiiv) begin
          load_s = 1'b1;
          // A further unit proves the held word is not the last one.
          if (hold_v_r) begin
            emit_s      = 1'b1;
            from_hold_s = 1'b1;
          end else begin
            emit_s = 1'b0;
          end
        end else begin
          clr_s       = 1'b1;
          state_nxt_s = IDLE;
          if (hold_v_r) begin
            emit_s      = 1'b1;
            last_s      = 1'b1;
            from_hold_s = 1'b1;
          end else if (lane_cnt_s != {CNT_W{1'b0}}) begin
            emit_s = 1'b1;
            last_s = 1'b1;
          end else begin
            runt_s = 1'b1;
          end
        end
      end
      default: begin
        clr_s       = 1'b1;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and header-skip counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      skip_cnt_r <= {SKIP_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      skip_cnt_r <= skip_nxt_s;
    end
  end

  // Hold register: parks each completed word until we know if it is the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r   <= {OUT_W{1'b0}};
      hold_v_r <= 1'b0;
    end else if (word_done_s) begin
      hold_r   <= word_full_s;
      hold_v_r <= 1'b1;
    end else if (from_hold_s) begin
      hold_v_r <= 1'b0;
    end
  end

  // Registered output stage; data and count hold between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      axiov    <= 1'b0;
      axiol    <= 1'b0;
      axiorunt <= 1'b0;
      axiod    <= {OUT_W{1'b0}};
      axiocnt  <= {CNT_W{1'b0}};
    end else begin
      axiov    <= emit_s;
      axiol    <= last_s;
      axiorunt <= runt_s;
      if (emit_s) begin
        axiod   <= from_hold_s ? hold_r : word_part_s;
        axiocnt <= from_hold_s ? CNT_W'(LANES) : lane_cnt_s;
      end
    end
  end

endmodule

// File: tb/tb_aggregate_frame.sv
// Self-checking bench for aggregate_frame: directed frames plus random
// frame streams, checked every cycle against a frame-level reference model.
module tb_aggregate_frame;

  logic clk = 1'b0;
  logic rst_n;

  // Instance A: default configuration (dibits -> 32-bit, 64-bit header, MSB first)
  logic        iv_a;
  logic [1:0]  id_a;
  logic        ov_a;
  logic [31:0] od_a;
  logic        ol_a;
  logic [4:0]  cnt_a;
  logic        runt_a;

  // Instance B: dibits -> 8-bit, no header, LSB-first lanes
  logic        iv_b;
  logic [1:0]  id_b;
  logic        ov_b;
  logic [7:0]  od_b;
  logic        ol_b;
  logic [2:0]  cnt_b;
  logic        runt_b;

  aggregate_frame dut_a (
    .clk(clk), .rst_n(rst_n), .axiiv(iv_a), .axiid(id_a),
    .axiov(ov_a), .axiod(od_a), .axiol(ol_a), .axiocnt(cnt_a), .axiorunt(runt_a)
  );

  aggregate_frame #(.IN_W(2), .OUT_W(8), .SKIP_BITS(0), .FIRST_MSB(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .axiiv(iv_b), .axiid(id_b),
    .axiov(ov_b), .axiod(od_b), .axiol(ol_b), .axiocnt(cnt_b), .axiorunt(runt_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus timeline (one entry per clock) and model expectations.
  int     tv_q[$];
  int     td_q[$];
  int     exp_v[];
  longint exp_d[];
  int     exp_l[];
  int     exp_c[];
  int     exp_r[];

  // Pulses observed on the DUT during the last run.
  longint obs_d[$];
  int     obs_l[$];
  int     obs_c[$];
  int     obs_runts;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic clear_tl();
    tv_q.delete(); td_q.delete();
    obs_d.delete(); obs_l.delete(); obs_c.delete();
    obs_runts = 0;
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) begin
      tv_q.push_back(0); td_q.push_back(0);
    end
  endtask

  task automatic add_rand_units(input int n);
    for (int i = 0; i < n; i++) begin
      tv_q.push_back(1); td_q.push_back(int'($urandom_range(0, 3)));
    end
  endtask

  // Push the low 2*n bits of w as n dibits, most significant dibit first.
  task automatic add_dibits(input longint w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      tv_q.push_back(1); td_q.push_back(int'((w >> (2 * i)) & 64'd3));
    end
  endtask

  // Reference model: for every frame (run of valid units) decide which words
  // appear, with which lanes, and on which cycle, from the frame rules alone.
  task automatic build_expect(input int lanes, input int skip, input int fmsb, input int inw);
    int n, c, s, p, m, lane, at, last;
    longint w;
    n = tv_q.size();
    exp_v = new[n]; exp_d = new[n]; exp_l = new[n]; exp_c = new[n]; exp_r = new[n];
    c = 0;
    while (c < n) begin
      if (tv_q[c] == 0) begin
        c++;
      end else begin
        s = c;
        while (c < n && tv_q[c] != 0) c++;
        p = (c - s) - skip;
        if (p <= 0) begin
          exp_r[c] = 1;
        end else begin
          for (int k = 0; k * lanes < p; k++) begin
            m = (p - k * lanes < lanes) ? (p - k * lanes) : lanes;
            w = 0;
            for (int j = 0; j < m; j++) begin
              lane = (fmsb != 0) ? (lanes - 1 - j) : j;
              w |= longint'(td_q[s + skip + k * lanes + j]) << (lane * inw);
            end
            if ((k + 1) * lanes < p) begin
              at = s + skip + (k + 1) * lanes; last = 0;
            end else begin
              at = c; last = 1;
            end
            exp_v[at] = 1; exp_d[at] = w; exp_l[at] = last; exp_c[at] = m;
          end
        end
      end
    end
  endtask

  // Drive the timeline into one instance and compare every cycle.
  task automatic run_tl(input int sel);
    logic   ov, ol, rt;
    longint od;
    int     oc;
    for (int c = 0; c < tv_q.size(); c++) begin
      @(negedge clk);
      if (sel == 0) begin
        iv_a = (tv_q[c] != 0); id_a = 2'(td_q[c]);
      end else begin
        iv_b = (tv_q[c] != 0); id_b = 2'(td_q[c]);
      end
      @(posedge clk);
      #1;
      if (sel == 0) begin
        ov = ov_a; od = longint'(od_a); ol = ol_a; oc = int'(cnt_a); rt = runt_a;
      end else begin
        ov = ov_b; od = longint'(od_b); ol = ol_b; oc = int'(cnt_b); rt = runt_b;
      end
      chk("axiov", longint'(ov), longint'(exp_v[c]));
      chk("axiorunt", longint'(rt), longint'(exp_r[c]));
      if (ov && exp_v[c] != 0) begin
        chk("axiod", od, exp_d[c]);
        chk("axiol", longint'(ol), longint'(exp_l[c]));
        chk("axiocnt", longint'(oc), longint'(exp_c[c]));
      end
      if (ov) begin
        obs_d.push_back(od); obs_l.push_back(int'(ol)); obs_c.push_back(oc);
      end
      if (rt) obs_runts++;
    end
    @(negedge clk);
    iv_a = 1'b0; iv_b = 1'b0;
  endtask

  // Pin an observed pulse to a hand-computed value.
  task automatic pin(input string name, input int idx, input longint d, input int l, input int c);
    if (idx < obs_d.size()) begin
      chk({name, "_data"}, obs_d[idx], d);
      chk({name, "_last"}, longint'(obs_l[idx]), longint'(l));
      chk({name, "_cnt"}, longint'(obs_c[idx]), longint'(c));
    end else begin
      chk({name, "_present"}, 0, 1);
    end
  endtask

  task automatic frame_deadbeef();
    clear_tl(); add_idle(2); add_rand_units(32); add_dibits(64'hDEADBEEF, 16); add_idle(3);
    build_expect(16, 32, 1, 2);
    run_tl(0);
    chk("deadbeef_pulses", longint'(obs_d.size()), 1);
    pin("deadbeef", 0, 64'hDEADBEEF, 1, 16);
    chk("deadbeef_runts", longint'(obs_runts), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    iv_a = 1'b0; id_a = 2'd0; iv_b = 1'b0; id_b = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_axiov", longint'(ov_a), 0);
    chk("rst_axiod", longint'(od_a), 0);
    chk("rst_axiol", longint'(ol_a), 0);
    chk("rst_axiocnt", longint'(cnt_a), 0);
    chk("rst_axiorunt", longint'(runt_a), 0);
    chk("rst_b_axiov", longint'(ov_b), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single full word frame
    frame_deadbeef();

    // Two full words and a 4-unit partial
    clear_tl(); add_idle(2); add_rand_units(32);
    add_dibits(64'h01234567, 16); add_dibits(64'h89ABCDEF, 16); add_dibits(64'hA5, 4);
    add_idle(3);
    build_expect(16, 32, 1, 2);
    run_tl(0);
    chk("t2_pulses", longint'(obs_d.size()), 3);
    pin("t2_w0", 0, 64'h01234567, 0, 16);
    pin("t2_w1", 1, 64'h89ABCDEF, 0, 16);
    pin("t2_w2", 2, 64'hA5000000, 1, 4);

    // Reset while a completed word is parked in the hold register
    clear_tl(); add_rand_units(32); add_dibits(64'h13579BDF, 16);
    for (int c = 0; c < tv_q.size(); c++) begin
      @(negedge clk);
      iv_a = 1'b1; id_a = 2'(td_q[c]);
      @(posedge clk);
      #1;
      chk("t5_pre_axiov", longint'(ov_a), 0);
    end
    @(negedge clk);
    iv_a = 1'b1; id_a = 2'd3;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_axiov", longint'(ov_a), 0);
    chk("t5_rst_axiod", longint'(od_a), 0);
    chk("t5_rst_axiocnt", longint'(cnt_a), 0);
    chk("t5_rst_axiol", longint'(ol_a), 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("t5_inrst_axiov", longint'(ov_a), 0);
    end
    @(negedge clk);
    iv_a = 1'b0; rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("t5_post_axiov", longint'(ov_a), 0);
      chk("t5_post_runt", longint'(runt_a), 0);
    end
    frame_deadbeef();

    // Runts: frame shorter than header, and frame of exactly the header
    clear_tl(); add_idle(2); add_rand_units(20); add_idle(2); add_rand_units(32); add_idle(3);
    build_expect(16, 32, 1, 2);
    run_tl(0);
    chk("t3_pulses", longint'(obs_d.size()), 0);
    chk("t3_runts", longint'(obs_runts), 2);

    // Back-to-back frames with a single idle cycle between them
    clear_tl(); add_idle(2);
    add_rand_units(32); add_dibits(64'hDEADBEEF, 16); add_idle(1);
    add_rand_units(32); add_dibits(64'h01234567, 16); add_idle(3);
    build_expect(16, 32, 1, 2);
    run_tl(0);
    chk("t6_pulses", longint'(obs_d.size()), 2);
    pin("t6_f0", 0, 64'hDEADBEEF, 1, 16);
    pin("t6_f1", 1, 64'h01234567, 1, 16);

    // Random frame stream on the default instance
    clear_tl(); add_idle(2);
    for (int f = 0; f < 14; f++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      if (kind == 0) add_rand_units(int'($urandom_range(1, 31)));
      else if (kind == 1) add_rand_units(32);
      else add_rand_units(32 + int'($urandom_range(1, 70)));
      add_idle(int'($urandom_range(1, 3)));
    end
    add_idle(3);
    build_expect(16, 32, 1, 2);
    run_tl(0);

    // LSB-first, headerless, byte-wide instance
    clear_tl(); add_idle(2);
    tv_q.push_back(1); td_q.push_back(1);
    tv_q.push_back(1); td_q.push_back(2);
    tv_q.push_back(1); td_q.push_back(3);
    tv_q.push_back(1); td_q.push_back(0);
    tv_q.push_back(1); td_q.push_back(2);
    add_idle(3);
    build_expect(4, 0, 0, 2);
    run_tl(1);
    chk("t4_pulses", longint'(obs_d.size()), 2);
    pin("t4_w0", 0, 64'h39, 0, 4);
    pin("t4_w1", 1, 64'h02, 1, 1);

    // Random frame stream on the byte-wide instance
    clear_tl(); add_idle(2);
    for (int f = 0; f < 16; f++) begin
      add_rand_units(int'($urandom_range(1, 20)));
      add_idle(int'($urandom_range(1, 2)));
    end
    add_idle(3);
    build_expect(4, 0, 0, 2);
    run_tl(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
